// File: rtl/uart_rx_fifo_core.sv
// uart_rx_fifo_core: oversampled UART receiver feeding a first-word-fall-through FIFO of
// {frm_err, par_err, data}, with trigger and RTS flow control. Optional char timeout: UART_RX_TIMEOUT_EN.
module uart_rx_fifo_core #(
  parameter int DATA_W     = 8,
  parameter int OSR        = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int RTS_MARGIN = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_tick,
  input  logic                          rxd,
  input  logic [3:0]                    cfg_data_bits,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic [$clog2(FIFO_DEPTH):0]   cfg_trig_lvl,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_par_err,
  output logic                          rd_frm_err,
  output logic                          overrun,
  output logic                          rx_trig_o,
  output logic                          rts,
  output logic                          rx_timeout_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TCK_W = $clog2(OSR);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int ENT_W = DATA_W + 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic              r_rxd_meta, r_rxd_sync, r_rxd_prev;
  state_t            r_state;
  logic [TCK_W-1:0]  r_tick_cnt;
  logic [BIT_W-1:0]  r_bit_idx;
  logic [DATA_W-1:0] r_shift;
  logic [BIT_W-1:0]  r_nbits;
  logic              r_par_en, r_par_odd, r_par_err;

  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overrun, r_trig, r_rts;

  logic [BIT_W-1:0]  w_nbits_clamped;
  logic              w_tick_wrap, w_push, w_pop, w_full, w_wr;
  logic [DATA_W-1:0] w_data;
  logic [ENT_W-1:0]  w_wdata, w_head;
  logic [CNT_W-1:0]  w_count_next, w_trig_lvl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
    end
  end

  always_comb begin
    w_nbits_clamped = BIT_W'(cfg_data_bits);
    if (cfg_data_bits < 4'd5)
      w_nbits_clamped = BIT_W'(5);
    else if (int'(cfg_data_bits) > DATA_W)
      w_nbits_clamped = BIT_W'(DATA_W);
  end

  // START samples at mid-bit (OSR/2), all later bits one full bit period apart.
  assign w_tick_wrap = baud_tick && (r_tick_cnt == ((r_state == S_START) ?
                       TCK_W'(OSR/2 - 1) : TCK_W'(OSR - 1)));
  assign w_push  = (r_state == S_STOP) && w_tick_wrap;
  assign w_data  = r_shift >> (BIT_W'(DATA_W) - r_nbits);
  assign w_wdata = {~r_rxd_sync, r_par_err, w_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_nbits    <= BIT_W'(DATA_W);
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_par_err  <= 1'b0;
    end else begin
      if (r_state != S_IDLE && baud_tick)
        r_tick_cnt <= w_tick_wrap ? '0 : r_tick_cnt + TCK_W'(1);
      case (r_state)
        S_IDLE: begin
          // Falling edge only, so a stop bit held low cannot re-trigger a frame.
          if (r_rxd_prev && !r_rxd_sync) begin
            r_state    <= S_START;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_nbits    <= w_nbits_clamped;
            r_par_en   <= cfg_parity_en;
            r_par_odd  <= cfg_parity_odd;
            r_par_err  <= 1'b0;
          end
        end
        S_START: if (w_tick_wrap) r_state <= r_rxd_sync ? S_IDLE : S_DATA;
        S_DATA: begin
          if (w_tick_wrap) begin
            r_shift   <= {r_rxd_sync, r_shift[DATA_W-1:1]};
            r_bit_idx <= r_bit_idx + BIT_W'(1);
            if (r_bit_idx == r_nbits - BIT_W'(1))
              r_state <= r_par_en ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (w_tick_wrap) begin
            r_par_err <= ((^r_shift) ^ r_rxd_sync) != r_par_odd;
            r_state   <= S_STOP;
          end
        end
        S_STOP:  if (w_tick_wrap) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_valid   = (r_count != '0);
  assign w_pop      = rd_valid && rd_ready;
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_wr       = w_push && (!w_full || w_pop);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_trig_lvl = (cfg_trig_lvl == '0) ? CNT_W'(1) : cfg_trig_lvl;
  assign {rd_frm_err, rd_par_err, rd_data} = rd_valid ? w_head : '0;

  always_comb begin
    w_count_next = r_count;
    if (w_wr && !w_pop)
      w_count_next = r_count + CNT_W'(1);
    else if (!w_wr && w_pop)
      w_count_next = r_count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= w_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
      r_trig    <= 1'b0;
      r_rts     <= 1'b1;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count   <= w_count_next;
      r_overrun <= w_push && w_full && !w_pop;
      r_trig    <= (w_count_next >= w_trig_lvl);
      r_rts     <= !(w_count_next > CNT_W'(FIFO_DEPTH - RTS_MARGIN));
    end
  end

  assign overrun   = r_overrun;
  assign rx_trig_o = r_trig;
  assign rts       = r_rts;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(4 * (DATA_W + 3) * OSR + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;
  logic [TO_W-1:0] w_to_limit;

  // Four character times of the most recently framed format.
  assign w_to_limit = TO_W'((int'(r_nbits) + 2 + int'(r_par_en)) * 4 * OSR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (w_wr || w_pop || !rd_valid) begin
      r_to_cnt <= '0;
      if (w_pop || !rd_valid) r_timeout <= 1'b0;
    end else if (r_state == S_IDLE && baud_tick && !r_timeout) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
      if (r_to_cnt == w_to_limit - TO_W'(1)) r_timeout <= 1'b1;
    end
  end

  assign rx_timeout_o = r_timeout;
`else
  assign rx_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_core.sv
// Scoreboard bench for uart_rx_fifo_core: serial frames built from random characters, expected
// FIFO entries queued at send time and compared by an independent monitor on every pop.
module tb_uart_rx_fifo_core;
  localparam int DATA_W = 8;
  localparam int OSR    = 16;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;
  localparam int TDIV   = 4;

  logic clk, rst, baud_tick, rxd;
  logic [3:0] cfg_data_bits;
  logic cfg_parity_en, cfg_parity_odd;
  logic [$clog2(DEPTH):0] cfg_trig_lvl;
  logic rd_ready, rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic rd_par_err, rd_frm_err, overrun, rx_trig_o, rts, rx_timeout_o;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ovr  = 0;
  int obs_ovr  = 0;
  int tick_edges = 0;
  int push_tick  = 0;
  logic [9:0] exp_q[$];

  uart_rx_fifo_core #(.DATA_W(DATA_W), .OSR(OSR), .FIFO_DEPTH(DEPTH), .RTS_MARGIN(MARGIN)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rxd(rxd),
    .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
    .cfg_trig_lvl(cfg_trig_lvl), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_par_err(rd_par_err), .rd_frm_err(rd_frm_err), .overrun(overrun),
    .rx_trig_o(rx_trig_o), .rts(rts), .rx_timeout_o(rx_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (TDIV - 1) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      tick_edges++;
      #1 baud_tick = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every pop the DUT performs must match the oldest expected entry.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 32'(rd_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(e[7:0]));
          check("rd_par_err", 32'(rd_par_err), 32'(e[8]));
          check("rd_frm_err", 32'(rd_frm_err), 32'(e[9]));
        end
      end
      if (overrun) obs_ovr++;
    end
  end

  task automatic wait_tick();
    do @(posedge clk); while (!baud_tick);
  endtask

  task automatic pop_one();
    @(posedge clk);
    #1 rd_ready = 1'b1;
    @(posedge clk);
    #1 rd_ready = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] d, input int bits, input bit pen, input bit podd,
                           input bit flip, input bit stop, input bit pop_at_stop);
    int nb, flen, n, lvl;
    logic [7:0] dm;
    logic [11:0] fr;
    bit psent, drop, perr;
    nb    = (bits < 5) ? 5 : ((bits > DATA_W) ? DATA_W : bits);
    dm    = d & 8'((1 << nb) - 1);
    psent = ((($countones(dm) % 2) == 1) ^ podd) ^ flip;
    perr  = pen && ((($countones(dm) + int'(psent)) % 2) != int'(podd));
    cfg_data_bits  = 4'(bits);
    cfg_parity_en  = pen;
    cfg_parity_odd = podd;
    drop = (exp_q.size() >= DEPTH) && !pop_at_stop;
    if (drop) exp_ovr++;
    else exp_q.push_back({~stop, perr, dm});
    fr = '0;
    for (int i = 0; i < nb; i++) fr[1 + i] = dm[i];
    flen = 1 + nb;
    if (pen) begin
      fr[flen] = psent;
      flen++;
    end
    fr[flen] = stop;
    flen++;
    wait_tick();
    #1 rxd = fr[0];
    for (int b = 1; b < flen; b++) begin
      repeat (OSR) wait_tick();
      #1 rxd = fr[b];
    end
    if (pop_at_stop) begin
      repeat (OSR/2 - 1) wait_tick();
      repeat (TDIV - 1) @(posedge clk);
      #1 rd_ready = 1'b1;
      @(posedge clk);
      #1 rd_ready = 1'b0;
    end else begin
      repeat (OSR/2) wait_tick();
      #1;
    end
    push_tick = tick_edges;
    n   = exp_q.size();
    lvl = (cfg_trig_lvl == 0) ? 1 : int'(cfg_trig_lvl);
    check("rd_valid_latency", 32'(rd_valid), 32'd1);
    check("overrun", 32'(overrun), 32'(drop));
    check("rts", 32'(rts), 32'(n <= DEPTH - MARGIN));
    check("rx_trig_o", 32'(rx_trig_o), 32'(n >= lvl));
    $display("TX data=%02h bits=%0d pen=%0d odd=%0d flip=%0d stop=%0d pop=%0d drop=%0d fill=%0d",
             dm, nb, pen, podd, flip, stop, pop_at_stop, drop, n);
    rxd = 1'b1;
    repeat (OSR/2) wait_tick();
  endtask

  initial begin
    bit any_valid;
    rst = 1'b1; rxd = 1'b1; rd_ready = 1'b0;
    cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_trig_lvl = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_tags", 32'({rd_par_err, rd_frm_err}), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_trig", 32'(rx_trig_o), 32'd0);
    check("rst_rts", 32'(rts), 32'd1);
    check("rst_timeout", 32'(rx_timeout_o), 32'd0);
    rst = 1'b0;

    rd_ready = 1'b1;
    send_char(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_char(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    send_char(8'h41, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Short low pulse on an idle line must be rejected as a glitch.
    any_valid = 1'b0;
    wait_tick();
    #1 rxd = 1'b0;
    repeat (4) wait_tick();
    #1 rxd = 1'b1;
    for (int i = 0; i < 3 * OSR; i++) begin
      wait_tick();
      #1 if (rd_valid) any_valid = 1'b1;
    end
    check("glitch_no_push", 32'(any_valid), 32'd0);

    for (int k = 0; k < 20; k++) begin
      bit pen;
      cfg_trig_lvl = 5'($urandom_range(0, 3));
      pen = 1'($urandom_range(0, 1));
      send_char(8'($urandom), $urandom_range(3, 10), pen, 1'($urandom_range(0, 1)),
                pen && ($urandom_range(0, 3) == 0), $urandom_range(0, 5) != 0, 1'b0);
    end

    // Fill without pops, then one dropped char and one accepted by a same-cycle pop.
    rd_ready = 1'b0;
    cfg_trig_lvl = 5'd4;
    for (int k = 0; k < DEPTH + 1; k++)
      send_char(8'($urandom), 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_char(8'($urandom), 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    while (exp_q.size() > 1) begin
      pop_one();
      check("drain_trig", 32'(rx_trig_o), 32'(exp_q.size() >= 4));
      check("drain_rts", 32'(rts), 32'(exp_q.size() <= DEPTH - MARGIN));
    end
    cfg_trig_lvl = '0;
    @(posedge clk);
    #1 check("trig_lvl0", 32'(rx_trig_o), 32'd1);
    pop_one();
    check("empty_trig", 32'(rx_trig_o), 32'd0);
    check("empty_valid", 32'(rd_valid), 32'd0);

    send_char(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef UART_RX_TIMEOUT_EN
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
        wait_tick();
        #1 seen = rx_timeout_o;
      end
      check("timeout_ticks", 32'(tick_edges - push_tick), 32'd640);
    end
`else
    repeat (700) wait_tick();
    #1 check("timeout_tied", 32'(rx_timeout_o), 32'd0);
`endif
    pop_one();
    check("timeout_clear", 32'(rx_timeout_o), 32'd0);

    // Reset in the middle of a frame with one char held in the FIFO.
    send_char(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_tick();
    #1 rxd = 1'b0;
    repeat (3 * OSR) wait_tick();
    #1 rst = 1'b1;
    exp_q.delete();
    #2;
    check("midrst_valid", 32'(rd_valid), 32'd0);
    check("midrst_data", 32'(rd_data), 32'd0);
    check("midrst_trig", 32'(rx_trig_o), 32'd0);
    check("midrst_rts", 32'(rts), 32'd1);
    check("midrst_timeout", 32'(rx_timeout_o), 32'd0);
    rxd = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10 * OSR) wait_tick();
    #1 check("midrst_no_push", 32'(rd_valid), 32'd0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("overrun_pulses", 32'(obs_ovr), 32'(exp_ovr));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
